// File: rtl/output_port_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_port_alloc_pkg
// Description : Shared router types for the output-port allocator: port count,
//               flit typing, the Switch-to-output pipeline bus, the router
//               configuration struct, allocator FSM states and the credit
//               counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package output_port_alloc_pkg;

    localparam int NUM_OF_PORTS = 5;
    localparam int PORT_W       = $clog2(NUM_OF_PORTS);

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } FLIT_T;

    typedef struct packed {
        FLIT_T             flit_type;
        logic [PORT_W-1:0] dest;
        logic [31:0]       data;
    } router_pipeline_bus_t;

    typedef struct packed {
        int unsigned x;
        int unsigned y;
    } router_conf_t;

    typedef enum logic {
        OP_IDLE   = 1'b0,
        OP_LOCKED = 1'b1
    } OP_STATE;

    // Counter must represent 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_alloc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request at or after the priority pointer, wrapping around.
// Ports       : req_i [N]       request vector
//               ptr_i [PORT_W]  highest-priority index
//               gnt_o [N]       one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import output_port_alloc_pkg::*;
#(
    parameter int N = NUM_OF_PORTS
) (
    input  logic [N-1:0]      req_i,
    input  logic [PORT_W-1:0] ptr_i,
    output logic [N-1:0]      gnt_o
);

    logic [PORT_W-1:0] w_idx;
    logic              w_found;

    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 0; off < N; off++) begin
            w_idx = PORT_W'((int'(ptr_i) + off) % N);
            if (!w_found && req_i[w_idx]) begin
                gnt_o[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_port_alloc.sv
`default_nettype none
// ============================================================================
// Module      : output_port_alloc
// Description : Per-output-port allocator and output stage. Round-robin
//               grants one packet at a time, holds ownership until the tail
//               flit, registers accepted flits toward the link and tracks
//               downstream buffer space with credits.
// Ports       : i_clk, i_rst (async, active-high)
//               i_outport_req [N]  request column from every input
//               i_s2o              flit driven by the Switch
//               i_credit_ret       downstream freed one slot
//               o_outport_ack [N]  one-hot same-cycle accept
//               o_flit, o_flit_valid  registered flit toward the link
//               o_busy             port owned by a packet
//               o_credit_err       sticky credit overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module output_port_alloc
    import output_port_alloc_pkg::*;
#(
    parameter router_conf_t router_conf = '{default: 9999},
    parameter int           PORT_ID     = 0,
    parameter int           BUF_DEPTH   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_OF_PORTS-1:0] i_outport_req,
    input  router_pipeline_bus_t    i_s2o,
    input  logic                    i_credit_ret,
    output logic [NUM_OF_PORTS-1:0] o_outport_ack,
    output router_pipeline_bus_t    o_flit,
    output logic                    o_flit_valid,
    output logic                    o_busy,
    output logic                    o_credit_err
);

    localparam int                  CREDIT_W = credit_w(BUF_DEPTH);
    localparam logic [CREDIT_W-1:0] C_FULL   = CREDIT_W'(BUF_DEPTH);

    OP_STATE              state_q,   state_d;
    logic [PORT_W-1:0]    owner_q,   owner_d;
    logic [PORT_W-1:0]    rr_ptr_q,  rr_ptr_d;
    logic [CREDIT_W-1:0]  credits_q, credits_d;
    logic                 err_q,     err_d;
    router_pipeline_bus_t flit_q;
    logic                 flit_valid_q;

    logic [NUM_OF_PORTS-1:0] w_gnt;
    logic [NUM_OF_PORTS-1:0] w_ack;
    logic [PORT_W-1:0]       w_gnt_idx;
    logic [PORT_W-1:0]       w_sel;
    logic                    w_accept;
    logic                    w_has_credit;
    logic                    w_unused_cfg;

    // Configuration is carried only for identification in simulation logs.
    assign w_unused_cfg = ^{router_conf, PORT_ID};

    assign w_has_credit = (credits_q != '0);

    rr_arbiter #(.N(NUM_OF_PORTS)) u_rr_arbiter (
        .req_i (i_outport_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            if (w_gnt[i]) w_gnt_idx = PORT_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        w_ack    = '0;
        w_accept = 1'b0;
        w_sel    = owner_q;
        case (state_q)
            OP_IDLE: begin
                if (w_has_credit) begin
                    w_ack    = w_gnt;
                    w_accept = |w_gnt;
                    w_sel    = w_gnt_idx;
                end
            end
            OP_LOCKED: begin
                // Owner keeps the ack even while not requesting; only a real
                // request turns it into an accepted flit.
                if (w_has_credit) begin
                    w_ack[owner_q] = 1'b1;
                    w_accept       = i_outport_req[owner_q];
                end
            end
            default: state_d = OP_IDLE;
        endcase

        if (w_accept) begin
            owner_d = w_sel;
            if (i_s2o.flit_type == TAIL_FLIT) begin
                state_d  = OP_IDLE;
                rr_ptr_d = (w_sel == PORT_W'(NUM_OF_PORTS - 1)) ? '0 : w_sel + PORT_W'(1);
            end else begin
                state_d = OP_LOCKED;
            end
        end
    end

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({w_accept, i_credit_ret})
            2'b10: credits_d = credits_q - CREDIT_W'(1);
            2'b01: begin
                if (credits_q == C_FULL) err_d = 1'b1;
                else                     credits_d = credits_q + CREDIT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= OP_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            credits_q    <= C_FULL;
            err_q        <= 1'b0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            credits_q    <= credits_d;
            err_q        <= err_d;
            flit_valid_q <= w_accept;
            if (w_accept) flit_q <= i_s2o;
        end
    end

    // Registers are already at reset values while i_rst is high, so the
    // arbiter would otherwise grant; the ack must stay silent during reset.
    assign o_outport_ack = w_ack & {NUM_OF_PORTS{~i_rst}};
    assign o_flit        = flit_q;
    assign o_flit_valid  = flit_valid_q;
    assign o_busy        = (state_q == OP_LOCKED);
    assign o_credit_err  = err_q;

endmodule
`default_nettype wire
